// File: rtl/hqm_rcfwl_gclk_sync_divider.sv
// rtl/hqm_rcfwl_gclk_sync_divider.sv - pll_sync-aligned ratio clock-enable generator with lock tracking
module hqm_rcfwl_gclk_sync_divider #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6,
    parameter int LOCK_CNT    = 4
) (
    input  logic             ckpredop,
    input  logic             rst_b,
    input  logic             pll_sync_out,
    input  logic             enable,
    input  logic [CNT_W-1:0] ratio,
    input  logic             err_clr,
    output logic             clk_en,
    output logic [CNT_W-1:0] phase,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    // Fewer than two metastability flops is never safe, so clamp the depth.
    localparam int         SS       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [SS-1:0]    sync_ff;
    logic             sync_d;
    logic             sync_edge;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ratio_q;
    logic [CNT_W-1:0] ratio_nxt;
    logic [CNT_W-1:0] ratio_sat;
    logic [CNT_W-1:0] phase_nxt;
    logic [3:0]       good_cnt;
    logic [3:0]       good_nxt;
    logic             clk_en_nxt;
    logic             sync_err_nxt;
    logic             at_last;
    logic             tracking;
    logic             aligned;
    logic             misaligned;

    // Synchronizer chain on the async marker plus one delay flop for edge detection
    always_ff @(posedge ckpredop or negedge rst_b) begin
        if (!rst_b) begin
            sync_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SS-2:0], pll_sync_out};
            sync_d  <= sync_ff[SS-1];
        end
    end

    assign sync_edge  = sync_ff[SS-1] & ~sync_d;
    assign ratio_sat  = (ratio == '0) ? CNT_W'(1) : ratio;
    assign at_last    = (phase == ratio_q - CNT_W'(1));
    assign tracking   = (state == ST_TRACK) || (state == ST_LOCKED);
    assign aligned    = sync_edge & at_last;
    assign misaligned = sync_edge & ~at_last & tracking;

    // State register
    always_ff @(posedge ckpredop or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enable low always wins and drops to IDLE
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_ACQUIRE;
                ST_ACQUIRE: if (sync_edge) state_nxt = (LOCK_CNT == 1) ? ST_LOCKED : ST_TRACK;
                ST_TRACK:   if (aligned && (good_cnt + 4'd1 >= LOCK_TGT)) state_nxt = ST_LOCKED;
                ST_LOCKED:  if (misaligned) state_nxt = ST_TRACK;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values: phase counter, alignment counter, ratio capture, status
    always_comb begin
        phase_nxt = '0;
        good_nxt  = '0;
        ratio_nxt = ratio_q;
        if (enable) begin
            case (state)
                ST_ACQUIRE: begin
                    if (sync_edge) begin
                        ratio_nxt = ratio_sat;
                        good_nxt  = 4'd1;
                    end
                end
                ST_TRACK, ST_LOCKED: begin
                    good_nxt = good_cnt;
                    if (misaligned) begin
                        good_nxt = 4'd1;
                    end else begin
                        phase_nxt = at_last ? '0 : phase + CNT_W'(1);
                        if (aligned && (state == ST_TRACK)) good_nxt = good_cnt + 4'd1;
                    end
                end
                default: good_nxt = '0;
            endcase
        end
        clk_en_nxt   = ((state_nxt == ST_TRACK) || (state_nxt == ST_LOCKED)) && (phase_nxt == '0);
        // A slip seen while locked beats a simultaneous clear request.
        sync_err_nxt = (enable && (state == ST_LOCKED) && misaligned) ? 1'b1 :
                       (err_clr ? 1'b0 : sync_err);
    end

    // Registered outputs and datapath state
    always_ff @(posedge ckpredop or negedge rst_b) begin
        if (!rst_b) begin
            clk_en   <= 1'b0;
            phase    <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
            ratio_q  <= CNT_W'(1);
            good_cnt <= '0;
        end else begin
            clk_en   <= clk_en_nxt;
            phase    <= phase_nxt;
            locked   <= (state_nxt == ST_LOCKED);
            sync_err <= sync_err_nxt;
            ratio_q  <= ratio_nxt;
            good_cnt <= good_nxt;
        end
    end

endmodule

// File: doc/hqm_rcfwl_gclk_sync_divider.md
# hqm_rcfwl_gclk_sync_divider

Consumer of the distributed clock spine and PLL sync marker at the rlink partition endpoint. Runs on the distributed spine clock and takes the pass-through pll_sync marker. Produces a divided clock-enable whose phase is aligned to pll_sync, plus lock and sticky misalignment status for downstream ratio-clocked logic.

## Interface
- SYNC_STAGES, 2: metastability flops on pll_sync (minimum 2).
- CNT_W, 6: width of ratio and phase counter.
- LOCK_CNT, 4: consecutive aligned sync edges (including the first) required for lock; range 1..15.
- ckpredop  input  1  distributed spine clock; all state on rising edge.
- rst_b  input  1  asynchronous assert, active-low reset.
- pll_sync_out  input  1  PLL sync marker from clkdist; treated as asynchronous.
- enable  input  1  block enable; low forces IDLE.
- ratio  input  CNT_W  divide ratio N; 0 is treated as 1.
- err_clr  input  1  clears sync_err.
- clk_en  output  1  one-cycle enable at phase 0 of every N-cycle period.
- phase  output  CNT_W  current phase counter, 0..N-1.
- locked  output  1  alignment locked.
- sync_err  output  1  sticky: misaligned edge seen while locked.

## Operation
- Synchronizer: SYNC_STAGES flops, then one delay flop. edge = sync & ~sync_d (rising edge only).
- ratio_q register: captured as max(ratio,1) only on the ACQUIRE edge. Changes to ratio in TRACK/LOCKED are ignored until re-acquire.
- Aligned edge: edge while phase == ratio_q-1. Misaligned edge: any other edge in TRACK/LOCKED.
- Phase counter: phase <= (phase == ratio_q-1) ? 0 : phase+1 in TRACK/LOCKED. A misaligned edge forces phase <= 0. Held at 0 in IDLE/ACQUIRE.
- clk_en (registered): high in every cycle where phase == 0 in TRACK/LOCKED; low otherwise. With ratio_q=1, clk_en is continuously high.
- good_cnt: 4-bit counter.
- FSM states:
  - IDLE: enable=0. Goes to ACQUIRE when enable=1.
  - ACQUIRE: waits for edge. On edge: phase<=0, clk_en<=1, good_cnt<=1, capture ratio_q. Goes to LOCKED if LOCK_CNT==1, else TRACK.
  - TRACK: on aligned edge, good_cnt++, and goes to LOCKED when good_cnt+1 == LOCK_CNT. On misaligned edge, phase<=0 and good_cnt<=1; stays in TRACK.
  - LOCKED: aligned edges change nothing. On misaligned edge, sync_err<=1, phase<=0, good_cnt<=1, goes to TRACK.
- locked = (state == LOCKED), registered.
- enable=0 in any state: go to IDLE next cycle. clk_en, locked, phase and good_cnt clear. sync_err is retained.
- sync_err: cleared when err_clr=1. If a set event and err_clr occur in the same cycle, set wins.

## Timing
- Reset values (rst_b low, asynchronous): state=IDLE, clk_en=0, phase=0, locked=0, sync_err=0, synchronizer and delay flops=0, ratio_q=1, good_cnt=0.
- Release of rst_b is synchronous to ckpredop. This block does not synchronize reset deassertion.
- pll_sync_out rising to edge: SYNC_STAGES cycles (plus up to 1 for async sampling).
- Edge to clk_en/phase update: 1 cycle, registered.
- The final aligned edge sets locked the next cycle. A misaligned edge clears locked and sets sync_err the next cycle.
- A pll_sync high pulse shorter than 1 ckpredop period may be missed; the source guarantees at least 2 cycles.
- Reset mid-operation: all outputs drop immediately, and the block re-acquires from IDLE after release.

## Test plan
- Lock: reset, enable=1, ratio=4, pll_sync rising every 8 cycles -> clk_en every 4 cycles with phase 0 one cycle after each edge detection; locked=1 one cycle after the 4th edge; sync_err=0.
- Ratio 0/1: ratio=0 with a 5-cycle sync period -> ratio_q=1, clk_en stuck high, phase=0, lock after 4 edges.
- Slip while locked: ratio=4, locked, then one edge arrives 1 cycle early -> sync_err=1, locked=0, phase restarts at 0 from that edge; relock after 3 further aligned edges; sync_err stays 1 until err_clr; err_clr coincident with a new slip leaves sync_err=1.
- Misalignment during TRACK: ratio=6, sync period 9 -> never locks; sync_err stays 0; phase resets at every edge.
- Ratio change and enable: change ratio from 4 to 8 while locked -> no effect; drop enable for 1 cycle -> IDLE, clk_en/locked/phase=0, sync_err held; re-acquire uses 8.
- Async reset: assert rst_b mid-period -> all outputs 0 in the same cycle without waiting for a clock; no clk_en until a new edge arrives after release.
